// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side blocks: arbiter state encoding and width helpers.
// Used by fifo_write_arbiter (burst lock enabled by FIFO_WRITE_ARB_BURST_EN) and rr_priority_picker.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Index width is never zero so a 1-bit index port always exists.
    function automatic int idx_width(input int num_req);
        return (clog2(num_req) > 1) ? clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping
// modulo numReq so a non-power-of-two requester count never yields an out-of-range index.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int numReq   = 4,
    parameter int idxWidth = idx_width(numReq)
) (
    input  logic [numReq-1:0]   req_i,
    input  logic [idxWidth-1:0] rr_ptr_i,
    output logic                found_o,
    output logic [idxWidth-1:0] winner_o
);

    localparam logic [idxWidth:0] NUM_REQ = (idxWidth + 1)'(numReq);

    logic [idxWidth:0]   sum;
    logic [idxWidth-1:0] idx;

    // Scanning from the farthest offset down lets the nearest hit overwrite earlier ones.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        sum      = '0;
        idx      = '0;
        for (int k = numReq - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_i} + (idxWidth + 1)'(k);
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = sum[idxWidth-1:0];
            if (req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the async FIFO write port, gated by the FIFO full flag.
// Define FIFO_WRITE_ARB_BURST_EN to keep a requester granted until its last beat or maxBurst beats.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int numReq    = 4,
    parameter int dataWidth = 8,
    parameter int maxBurst  = 16,
    localparam int idxWidth = idx_width(numReq)
) (
    input  logic                        writeClkIn,
    input  logic                        writeRstIn,
    input  logic [numReq-1:0]           reqIn,
    input  logic [numReq-1:0]           lastIn,
    input  logic [numReq*dataWidth-1:0] dataIn,
    input  logic                        fifoFullIn,
    output logic [numReq-1:0]           ackOut,
    output logic                        writeEnableOut,
    output logic [dataWidth-1:0]        writeDataOut,
    output logic [idxWidth-1:0]         grantIdxOut,
    output logic                        busyOut
);

    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numReq - 1);

    logic [idxWidth-1:0] rr_ptr_q;
    logic [idxWidth-1:0] grant_idx_q;
    logic [idxWidth-1:0] pick_ptr;
    logic [idxWidth-1:0] winner;
    logic [numReq-1:0]   eligible;
    logic                found;
    logic                ack_valid;

    function automatic logic [idxWidth-1:0] next_idx(input logic [idxWidth-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    rr_priority_picker #(
        .numReq   (numReq),
        .idxWidth (idxWidth)
    ) u_picker (
        .req_i    (eligible),
        .rr_ptr_i (pick_ptr),
        .found_o  (found),
        .winner_o (winner)
    );

    // Same full flag the FIFO uses for its pointer, so both agree on every accepted beat.
    assign ack_valid      = found & ~fifoFullIn & ~writeRstIn;
    assign ackOut         = ack_valid ? (numReq'(1) << winner) : '0;
    assign writeEnableOut = ack_valid;
    assign writeDataOut   = ack_valid ? dataIn[int'(winner)*dataWidth +: dataWidth] : '0;
    assign grantIdxOut    = grant_idx_q;

`ifdef FIFO_WRITE_ARB_BURST_EN
    localparam int CNT_W = clog2(maxBurst + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(maxBurst - 1);

    arb_state_e          state_q;
    logic [idxWidth-1:0] owner_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic                busy_q;

    // During a burst only the owner can win; the picker then trivially returns it.
    assign eligible = (state_q == ARB_BURST) ? (reqIn & (numReq'(1) << owner_q)) : reqIn;
    assign pick_ptr = (state_q == ARB_BURST) ? owner_q : rr_ptr_q;
    assign busyOut  = busy_q;

    always_ff @(posedge writeClkIn) begin
        if (writeRstIn) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else if (ack_valid) begin
            grant_idx_q <= winner;
            case (state_q)
                ARB_IDLE: begin
                    if (!lastIn[winner]) begin
                        state_q    <= ARB_BURST;
                        owner_q    <= winner;
                        beat_cnt_q <= CNT_W'(1);
                        busy_q     <= 1'b1;
                    end else begin
                        rr_ptr_q <= next_idx(winner);
                    end
                end
                ARB_BURST: begin
                    if (lastIn[owner_q] || (beat_cnt_q == LAST_BEAT)) begin
                        state_q    <= ARB_IDLE;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        rr_ptr_q   <= next_idx(owner_q);
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{lastIn, 32'(maxBurst)};
    assign eligible   = reqIn;
    assign pick_ptr   = rr_ptr_q;
    assign busyOut    = 1'b0;

    always_ff @(posedge writeClkIn) begin
        if (writeRstIn) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else if (ack_valid) begin
            grant_idx_q <= winner;
            rr_ptr_q    <= next_idx(winner);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, corner sequences, random run against a reference model.
// Expectations follow FIFO_WRITE_ARB_BURST_EN when it is defined for the build.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_WRITE_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] data;
    logic            full;
    logic [N-1:0]    ack;
    logic            we;
    logic [DW-1:0]   wdata;
    logic [1:0]      gidx;
    logic            busy;

    fifo_write_arbiter #(.numReq(N), .dataWidth(DW), .maxBurst(MB)) u_dut (
        .writeClkIn     (clk),
        .writeRstIn     (rst),
        .reqIn          (req),
        .lastIn         (last),
        .dataIn         (data),
        .fifoFullIn     (full),
        .ackOut         (ack),
        .writeEnableOut (we),
        .writeDataOut   (wdata),
        .grantIdxOut    (gidx),
        .busyOut        (busy)
    );

    // Three-requester instance for the non-power-of-two wrap case.
    logic          rst3;
    logic [2:0]    req3;
    logic [2:0]    last3;
    logic [23:0]   data3;
    logic          full3;
    logic [2:0]    ack3;
    logic          we3;
    logic [7:0]    wdata3;
    logic [1:0]    gidx3;
    logic          busy3;

    fifo_write_arbiter #(.numReq(3), .dataWidth(8), .maxBurst(MB)) u_dut3 (
        .writeClkIn     (clk),
        .writeRstIn     (rst3),
        .reqIn          (req3),
        .lastIn         (last3),
        .dataIn         (data3),
        .fifoFullIn     (full3),
        .ackOut         (ack3),
        .writeEnableOut (we3),
        .writeDataOut   (wdata3),
        .grantIdxOut    (gidx3),
        .busyOut        (busy3)
    );

    // ---------------- scoreboard / model state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] dat[N];

    int m_ptr, m_owner, m_cnt, m_grant;
    bit m_busy;
    logic [N-1:0] exp_ack;
    int exp_idx;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic         full;
        logic         rst;
        logic [N-1:0] ack;
        int           grant;
        int           busy;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_grant = 0; m_busy = 0;
    endtask

    task automatic model_predict();
        exp_ack = '0;
        exp_idx = -1;
        if (!rst && !full) begin
            if (m_busy) begin
                if (req[m_owner]) exp_idx = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (exp_idx < 0 && req[i]) exp_idx = i;
                end
            end
        end
        if (exp_idx >= 0) exp_ack[exp_idx] = 1'b1;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (exp_idx >= 0) begin
            m_grant = exp_idx;
            if (!m_busy) begin
                if (BURST_ON && !last[exp_idx]) begin
                    m_busy = 1; m_owner = exp_idx; m_cnt = 1;
                end else begin
                    m_ptr = (exp_idx + 1) % N;
                end
            end else if (last[m_owner] || (m_cnt + 1 == MB)) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic f,
                         input logic rs, input bit use_t, input logic [N-1:0] t_ack,
                         input int t_grant, input int t_busy);
        req  = r;
        last = l;
        full = f;
        rst  = rs;
        for (int i = 0; i < N; i++) data[i*DW +: DW] = dat[i];
        #1;
        model_predict();
        chk("ack", ack, exp_ack);
        chk("we", we, |exp_ack);
        chk("wdata", wdata, (exp_idx >= 0) ? dat[exp_idx] : '0);
        chk("grant", gidx, m_grant);
        chk("busy", busy, m_busy);
        if (exp_idx >= 0) exp_q.push_back(dat[exp_idx]);
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 1, 0);
            end else begin
                chk("sb_data", wdata, exp_q.pop_front());
            end
        end
        if (use_t) begin
            chk("vec_ack", ack, t_ack);
            if (t_grant >= 0) chk("vec_grant", gidx, t_grant);
            if (t_busy >= 0) chk("vec_busy", busy, t_busy);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_vec(input int i, input logic [N-1:0] r, input logic [N-1:0] l,
                           input logic f, input logic rs, input logic [N-1:0] a,
                           input int g, input int b);
        tbl[i].req = r; tbl[i].last = l; tbl[i].full = f; tbl[i].rst = rs;
        tbl[i].ack = a; tbl[i].grant = g; tbl[i].busy = b;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1; req = '0; last = '0; data = '0; full = 0;
        rst3 = 1; req3 = '0; last3 = 3'b111; data3 = 24'h33_22_11; full3 = 0;
        for (int i = 0; i < N; i++) dat[i] = 8'(8'hA0 + i);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst3 = 0;

        // Reset hold, fairness rotation, full backpressure then release.
        for (int i = 0; i < 3; i++) set_vec(i, 4'b1111, 4'b1111, 0, 1, 4'b0000, 0, 0);
        set_vec(3,  4'b1111, 4'b1111, 0, 0, 4'b0001, 0, 0);
        set_vec(4,  4'b1111, 4'b1111, 0, 0, 4'b0010, 0, 0);
        set_vec(5,  4'b1111, 4'b1111, 0, 0, 4'b0100, 1, 0);
        set_vec(6,  4'b1111, 4'b1111, 0, 0, 4'b1000, 2, 0);
        set_vec(7,  4'b1111, 4'b1111, 0, 0, 4'b0001, 3, 0);
        set_vec(8,  4'b1111, 4'b1111, 0, 0, 4'b0010, 0, 0);
        set_vec(9,  4'b1111, 4'b1111, 0, 0, 4'b0100, 1, 0);
        set_vec(10, 4'b1111, 4'b1111, 0, 0, 4'b1000, 2, 0);
        for (int i = 11; i < 16; i++) set_vec(i, 4'b0100, 4'b1111, 1, 0, 4'b0000, 3, 0);
        set_vec(16, 4'b0100, 4'b1111, 0, 0, 4'b0100, 3, 0);
        set_vec(17, 4'b0000, 4'b1111, 0, 0, 4'b0000, 2, 0);
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].req, tbl[i].last, tbl[i].full, tbl[i].rst, 1,
                  tbl[i].ack, tbl[i].grant, tbl[i].busy);
        end

        // Burst of three beats from requester 1 with everyone requesting.
        cycle(4'b0010, 4'b0000, 0, 0, 1, 4'b0010, -1, 0);
        cycle(4'b1111, 4'b1101, 0, 0, 1, BURST_ON ? 4'b0010 : 4'b0100, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b1111, 0, 0, 1, BURST_ON ? 4'b0010 : 4'b1000, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b1111, 0, 0, 1, BURST_ON ? 4'b0100 : 4'b0001, -1, 0);

        // Requester 0 never marks last: forced release after maxBurst beats.
        cycle(4'b0001, 4'b0000, 0, 0, 1, 4'b0001, -1, -1);
        cycle(4'b1111, 4'b0000, 0, 0, 1, BURST_ON ? 4'b0001 : 4'b0010, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b0000, 0, 0, 1, BURST_ON ? 4'b0001 : 4'b0100, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b0000, 0, 0, 1, BURST_ON ? 4'b0001 : 4'b1000, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b0000, 0, 0, 1, BURST_ON ? 4'b0010 : 4'b0001, -1, 0);

        // Reset while requester 1 holds a burst; release returns to IDLE with pointer 0.
        cycle(4'b1111, 4'b0000, 0, 1, 1, 4'b0000, -1, int'(BURST_ON));
        cycle(4'b1111, 4'b1111, 0, 0, 1, 4'b0001, 0, 0);
        cycle(4'b0000, 4'b1111, 0, 0, 1, 4'b0000, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
            cycle(4'($urandom_range(0, 15)), 4'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 60) == 0), 0, '0, -1, -1);
        end
        cycle(4'b0000, 4'b1111, 0, 1, 0, '0, -1, -1);
        req = '0;

        // Three-requester wrap: pointer 2 with requests 0 and 2.
        req3 = 3'b010;
        #1;
        chk("wrap_ack1", ack3, 3'b010);
        @(posedge clk); @(negedge clk);
        req3 = 3'b101;
        #1;
        chk("wrap_ack2", ack3, 3'b100);
        chk("wrap_data2", wdata3, 8'h33);
        chk("wrap_grant1", gidx3, 2'd1);
        @(posedge clk); @(negedge clk);
        #1;
        chk("wrap_ack0", ack3, 3'b001);
        chk("wrap_data0", wdata3, 8'h11);
        chk("wrap_grant2", gidx3, 2'd2);
        @(posedge clk); @(negedge clk);
        req3 = 3'b000;
        #1;
        chk("wrap_idle", ack3, 3'b000);
        chk("wrap_we", we3, 1'b0);
        chk("wrap_grant0", gidx3, 2'd0);
        chk("wrap_busy", busy3, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
